// File: rtl/audio_framer.sv
// Sliding-window audio framer: line-in samples land in a 2*FRAME_LEN ring and
// overlapping frames of FRAME_LEN samples, HOP samples apart, stream out oldest first.
package constants;
    localparam int SYNTH_WIDTH = 24;
endpackage

module audio_framer
    import constants::*;
#(
    parameter int FRAME_LEN = 512,
    parameter int HOP       = 256
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          sample_valid_in,
    input  logic signed [SYNTH_WIDTH-1:0] sample_in,
    input  logic                          frame_ready_in,
    output logic                          frame_valid_out,
    output logic signed [SYNTH_WIDTH-1:0] frame_data_out,
    output logic [$clog2(FRAME_LEN)-1:0]  frame_idx_out,
    output logic                          frame_last_out,
    output logic                          overrun_out,
    output logic                          busy_out
);

    localparam int IW = $clog2(FRAME_LEN);
    localparam int AW = IW + 1;
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FL_C  = CW'(FRAME_LEN);
    localparam logic [CW-1:0] HOP_C = CW'(HOP);
    localparam logic [AW-1:0] FL_A  = AW'(FRAME_LEN);

    typedef enum logic [1:0] {FILL, WAIT, STREAM} state_t;

    state_t state_q, state_d;

    logic                          rst_q;
    logic signed [SYNTH_WIDTH-1:0] ring [0:2*FRAME_LEN-1];
    logic [AW-1:0]                 wp_q;
    logic [AW-1:0]                 rd_addr_q;
    logic [CW-1:0]                 new_cnt_q, new_cnt_d, cnt_base;
    logic [CW-1:0]                 iss_cnt_q;
    logic [AW-1:0]                 start_addr;
    logic                          start_stream;
    logic                          accept;
    logic                          beat_done;
    logic                          issue;

    // Single-stage release so the first sample lands on the second edge after deassertion.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) rst_q <= 1'b1;
        else        rst_q <= 1'b0;
    end

    always_comb begin
        accept       = sample_valid_in && !((state_q == STREAM) && (new_cnt_q == FL_C));
        beat_done    = frame_valid_out && frame_ready_in;
        issue        = (state_q == STREAM) && (iss_cnt_q != FL_C) &&
                       (!frame_valid_out || frame_ready_in);
        state_d      = state_q;
        start_stream = 1'b0;
        start_addr   = '0;
        cnt_base     = new_cnt_q;
        case (state_q)
            // In FILL the new-sample counter equals the total written since reset.
            FILL: begin
                if (new_cnt_q == FL_C) begin
                    state_d      = STREAM;
                    start_stream = 1'b1;
                    cnt_base     = '0;
                end
            end
            WAIT: begin
                if (new_cnt_q >= HOP_C) begin
                    state_d      = STREAM;
                    start_stream = 1'b1;
                    start_addr   = wp_q - FL_A;
                    cnt_base     = new_cnt_q - HOP_C;
                end
            end
            STREAM: begin
                if (beat_done && frame_last_out) state_d = WAIT;
            end
            default: state_d = FILL;
        endcase
        new_cnt_d = cnt_base + {{(CW-1){1'b0}}, accept};
    end

    always_ff @(posedge clk_in) begin
        if (accept && !rst_q) ring[wp_q] <= sample_in;
    end

    // The output register doubles as the ring's registered read port; it only
    // loads when the current beat is empty or being taken, so stalls hold it.
    always_ff @(posedge clk_in or posedge rst_q) begin
        if (rst_q) begin
            state_q         <= FILL;
            wp_q            <= '0;
            new_cnt_q       <= '0;
            rd_addr_q       <= '0;
            iss_cnt_q       <= '0;
            overrun_out     <= 1'b0;
            frame_valid_out <= 1'b0;
            frame_data_out  <= '0;
            frame_idx_out   <= '0;
            frame_last_out  <= 1'b0;
        end else begin
            state_q   <= state_d;
            new_cnt_q <= new_cnt_d;
            if (accept) wp_q <= wp_q + 1'b1;
            if (sample_valid_in && !accept) overrun_out <= 1'b1;
            if (start_stream) begin
                rd_addr_q <= start_addr;
                iss_cnt_q <= '0;
            end else if (issue) begin
                rd_addr_q <= rd_addr_q + 1'b1;
                iss_cnt_q <= iss_cnt_q + 1'b1;
            end
            if (issue) begin
                frame_valid_out <= 1'b1;
                frame_data_out  <= ring[rd_addr_q];
                frame_idx_out   <= iss_cnt_q[IW-1:0];
                frame_last_out  <= (iss_cnt_q == FL_C - 1'b1);
            end else if (beat_done) begin
                frame_valid_out <= 1'b0;
                frame_last_out  <= 1'b0;
            end
        end
    end

    assign busy_out = (state_q == STREAM);

endmodule

// File: tb/tb_audio_framer.sv
// Directed bench for audio_framer with FRAME_LEN=8, HOP=4: overlapping frames,
// backpressure, overrun and mid-frame reset.
module tb_audio_framer;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               sample_valid_in;
    logic signed [23:0] sample_in;
    logic               frame_ready_in;
    logic               frame_valid_out;
    logic signed [23:0] frame_data_out;
    logic [2:0]         frame_idx_out;
    logic               frame_last_out;
    logic               overrun_out;
    logic               busy_out;

    int n_checks = 0;
    int n_fail   = 0;

    audio_framer #(.FRAME_LEN(8), .HOP(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_valid_in (sample_valid_in),
        .sample_in       (sample_in),
        .frame_ready_in  (frame_ready_in),
        .frame_valid_out (frame_valid_out),
        .frame_data_out  (frame_data_out),
        .frame_idx_out   (frame_idx_out),
        .frame_last_out  (frame_last_out),
        .overrun_out     (overrun_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic v, input int s, input logic r);
        sample_valid_in = v;
        sample_in       = 24'(s);
        frame_ready_in  = r;
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " valid"},   32'(frame_valid_out), 0);
        checkOutput({tag, " last"},    32'(frame_last_out),  0);
        checkOutput({tag, " idx"},     32'(frame_idx_out),   0);
        checkOutput({tag, " data"},    32'(frame_data_out),  0);
        checkOutput({tag, " overrun"}, 32'(overrun_out),     0);
        checkOutput({tag, " busy"},    32'(busy_out),        0);
    endtask

    // Eight beats with ready held high; optionally feeds four new samples from feed_from.
    task automatic runFrame(input string tag, input int first, input int feed_from);
        for (int j = 0; j < 8; j++) begin
            applyStimulus(feed_from != 0 && j < 4, feed_from + j, 1'b1);
            checkOutput({tag, " valid"}, 32'(frame_valid_out), 1);
            checkOutput({tag, " data"},  32'(frame_data_out),  32'(first + j));
            checkOutput({tag, " idx"},   32'(frame_idx_out),   32'(j));
            checkOutput({tag, " last"},  32'(frame_last_out),  (j == 7) ? 1 : 0);
        end
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput({tag, " end valid"}, 32'(frame_valid_out), 0);
        checkOutput({tag, " end busy"},  32'(busy_out),        0);
    endtask

    initial begin
        logic [3:0] bp_pat;
        int         b;
        int         p;
        logic       r;

        rst_in          = 1'b1;
        sample_valid_in = 1'b0;
        sample_in       = '0;
        frame_ready_in  = 1'b0;
        @(posedge clk_in);
        #1;
        checkAllZero("reset");
        rst_in = 1'b0;
        applyStimulus(1'b0, 0, 1'b1);

        $display("[TB] first three frames, hop 4");
        for (int k = 1; k <= 8; k++) applyStimulus(1'b1, k, 1'b1);
        checkOutput("fill done busy", 32'(busy_out), 0);
        checkOutput("fill done valid", 32'(frame_valid_out), 0);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("f1 entry busy", 32'(busy_out), 1);
        checkOutput("f1 entry valid", 32'(frame_valid_out), 0);
        runFrame("f1", 1, 9);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("f2 entry busy", 32'(busy_out), 1);
        runFrame("f2", 5, 13);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("f3 entry busy", 32'(busy_out), 1);
        runFrame("f3", 9, 0);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("idle wait busy", 32'(busy_out), 0);

        $display("[TB] backpressure 1,0,0,1");
        for (int k = 17; k <= 20; k++) applyStimulus(1'b1, k, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("bp entry busy", 32'(busy_out), 1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("bp first data", 32'(frame_data_out), 13);
        bp_pat = 4'b1001;
        b = 0;
        p = 0;
        while (b < 8 && p < 40) begin
            r = bp_pat[p[1:0]];
            applyStimulus(1'b0, 0, r);
            if (r) b++;
            if (b < 8) begin
                checkOutput("bp valid", 32'(frame_valid_out), 1);
                checkOutput("bp data",  32'(frame_data_out),  32'(13 + b));
                checkOutput("bp idx",   32'(frame_idx_out),   32'(b));
                checkOutput("bp last",  32'(frame_last_out),  (b == 7) ? 1 : 0);
            end else begin
                checkOutput("bp end valid", 32'(frame_valid_out), 0);
            end
            p++;
        end
        checkOutput("bp beats transferred", 32'(b), 8);

        $display("[TB] overrun with ready low");
        rst_in = 1'b1;
        #1;
        checkAllZero("reset2");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        applyStimulus(1'b0, 0, 1'b0);
        for (int k = 1; k <= 8; k++) applyStimulus(1'b1, k, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 9 + i, 1'b0);
            if (i == 7) checkOutput("ovr before drop", 32'(overrun_out), 0);
            if (i == 8) checkOutput("ovr after drop",  32'(overrun_out), 1);
        end
        checkOutput("ovr stall valid", 32'(frame_valid_out), 1);
        checkOutput("ovr stall data",  32'(frame_data_out),  1);
        checkOutput("ovr stall idx",   32'(frame_idx_out),   0);
        for (int j = 1; j < 8; j++) begin
            applyStimulus(1'b0, 0, 1'b1);
            checkOutput("ovr frame data", 32'(frame_data_out), 32'(j + 1));
            checkOutput("ovr frame idx",  32'(frame_idx_out),  32'(j));
        end
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("ovr end valid", 32'(frame_valid_out), 0);
        checkOutput("ovr sticky", 32'(overrun_out), 1);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("ovr next busy", 32'(busy_out), 1);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("ovr next data", 32'(frame_data_out), 9);
        checkOutput("ovr sticky2", 32'(overrun_out), 1);

        $display("[TB] reset at beat 3");
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("pre-reset idx", 32'(frame_idx_out), 3);
        rst_in = 1'b1;
        #1;
        checkAllZero("midframe reset");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        applyStimulus(1'b1, 99, 1'b1);
        checkOutput("release valid", 32'(frame_valid_out), 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 101 + k, 1'b1);
            checkOutput("refill valid", 32'(frame_valid_out), 0);
        end
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("f4 entry busy", 32'(busy_out), 1);
        runFrame("f4", 101, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
